pipeline_hazard_ctrl: RTL and testbench

Central sequencing controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Detects load-use hazards, control redirects resolved in MEM, and multi-cycle data-memory accesses.
- Drives the stage-register enable, flush and bubble controls, and keeps saturating hazard statistics.
- Sits beside the pipeline top level; all pipeline registers and the PC take their enable/flush from this block.

---
 rtl/pipeline_hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for the 5-stage pipeline: resolves memory waits, MEM-stage
// redirects and load-use hazards into stage enable/flush controls, with saturating stats.
module pipeline_hazard_ctrl #(
    parameter int IMEM_LATENCY = 1,
    parameter int MEM_TIMEOUT  = 64,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             mem_redirect,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             ex_mem_flush,
    output logic             mem_wb_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_err
);

    localparam int                WCNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] TIMEOUT_V = WCNT_W'(MEM_TIMEOUT);
    localparam logic [2:0]        LAT_V     = 3'(IMEM_LATENCY);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        fcnt_q, fcnt_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;
    logic              err_q, err_d;

    logic mem_busy, timeout_hit, wait_now, redirect_now, load_use, lu_now;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign mem_busy     = dmem_req & ~dmem_ready;
    // A wait that has run its full budget is released as though the memory answered.
    assign timeout_hit  = (state_q == MEM_WAIT) && (wcnt_q == TIMEOUT_V) && mem_busy;
    assign wait_now     = mem_busy & ~timeout_hit;
    assign redirect_now = ~wait_now & mem_redirect;
    assign load_use     = ex_mem_read && (ex_rt != 5'd0) &&
                          ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    assign lu_now       = ~wait_now & ~redirect_now & load_use;

    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_en     = 1'b1;
        ex_mem_flush  = 1'b0;
        mem_wb_bubble = 1'b0;
        if (!rst) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_flush  = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (wait_now) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (redirect_now) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else begin
            if (state_q == FLUSH)
                if_id_flush = 1'b1;
            if (lu_now) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        wcnt_d  = '0;
        stall_d = stall_q;
        flush_d = flush_q;
        err_d   = err_q | timeout_hit;
        if (wait_now) begin
            // Flush down-counter is left untouched so an interrupted FLUSH resumes.
            state_d = MEM_WAIT;
            wcnt_d  = (state_q == MEM_WAIT) ? wcnt_q + WCNT_W'(1) : WCNT_W'(1);
            stall_d = sat_inc(stall_q);
        end else if (redirect_now) begin
            flush_d = sat_inc(flush_q);
            if (IMEM_LATENCY > 0) begin
                state_d = FLUSH;
                fcnt_d  = LAT_V;
            end else begin
                state_d = RUN;
                fcnt_d  = '0;
            end
        end else begin
            if (lu_now)
                stall_d = sat_inc(stall_q);
            case (state_q)
                FLUSH: begin
                    if (fcnt_q <= 3'd1) begin
                        state_d = RUN;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d  = fcnt_q - 3'd1;
                    end
                end
                MEM_WAIT: state_d = (fcnt_q != 3'd0) ? FLUSH : RUN;
                default:  state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            fcnt_q  <= '0;
            wcnt_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            wcnt_q  <= wcnt_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
            err_q   <= err_d;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
    assign mem_err   = err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a second narrow-counter instance checks saturation.
module tb_pipeline_hazard_ctrl;

    localparam logic [7:0] C_NORM  = 8'hD4;
    localparam logic [7:0] C_RST   = 8'h2B;
    localparam logic [7:0] C_LU    = 8'h1C;
    localparam logic [7:0] C_REDIR = 8'hFE;
    localparam logic [7:0] C_FLUSH = 8'hF4;
    localparam logic [7:0] C_WAIT  = 8'h01;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_mem_read, mem_redirect, dmem_req, dmem_ready;
    logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic        ex_mem_en, ex_mem_flush, mem_wb_bubble, mem_err;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_en, s_id_ex_flush;
    logic        s_ex_mem_en, s_ex_mem_flush, s_mem_wb_bubble, s_mem_err;
    logic [1:0]  s_stall_cnt, s_flush_cnt;
    logic [7:0]  ctl;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                  ex_mem_en, ex_mem_flush, mem_wb_bubble};

    pipeline_hazard_ctrl #(.IMEM_LATENCY(1), .MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_redirect(mem_redirect),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
        .ex_mem_flush(ex_mem_flush), .mem_wb_bubble(mem_wb_bubble),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_err(mem_err)
    );

    pipeline_hazard_ctrl #(.IMEM_LATENCY(1), .MEM_TIMEOUT(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_redirect(mem_redirect),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(s_pc_en), .if_id_en(s_if_id_en), .if_id_flush(s_if_id_flush),
        .id_ex_en(s_id_ex_en), .id_ex_flush(s_id_ex_flush), .ex_mem_en(s_ex_mem_en),
        .ex_mem_flush(s_ex_mem_flush), .mem_wb_bubble(s_mem_wb_bubble),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .mem_err(s_mem_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; mem_redirect = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        #2;
        chk("reset_ctl", 32'(ctl), 32'(C_RST));
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("post_reset_ctl", 32'(ctl), 32'(C_NORM));
        chk("post_reset_stall", 32'(stall_cnt), 32'd0);
        chk("post_reset_flush", 32'(flush_cnt), 32'd0);
        chk("post_reset_err", 32'(mem_err), 32'd0);
        next_cycle();

        // load-use on rs
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        @(negedge clk); chk("lu_rs_ctl", 32'(ctl), 32'(C_LU));
        next_cycle();
        ex_mem_read = 1'b0;
        @(negedge clk); chk("lu_rs_after", 32'(ctl), 32'(C_NORM));
        chk("lu_rs_stall", 32'(stall_cnt), 32'd1);
        next_cycle();

        // register 0 never stalls
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        @(negedge clk); chk("lu_r0_ctl", 32'(ctl), 32'(C_NORM));
        next_cycle();
        chk("lu_r0_stall", 32'(stall_cnt), 32'd1);

        // rt match only counts when rt is a source
        ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0;
        @(negedge clk); chk("lu_rt_unused", 32'(ctl), 32'(C_NORM));
        next_cycle();
        id_uses_rt = 1'b1;
        @(negedge clk); chk("lu_rt_used", 32'(ctl), 32'(C_LU));
        next_cycle();
        clear_inputs();
        @(negedge clk); chk("lu_rt_stall", 32'(stall_cnt), 32'd2);
        next_cycle();

        // redirect then IMEM_LATENCY=1 flush cycle
        mem_redirect = 1'b1;
        @(negedge clk); chk("redir_c0", 32'(ctl), 32'(C_REDIR));
        next_cycle();
        mem_redirect = 1'b0;
        @(negedge clk); chk("redir_c1", 32'(ctl), 32'(C_FLUSH));
        next_cycle();
        @(negedge clk); chk("redir_c2", 32'(ctl), 32'(C_NORM));
        chk("redir_fcnt", 32'(flush_cnt), 32'd1);
        next_cycle();

        // redirect again while in FLUSH restarts the sequence
        mem_redirect = 1'b1;
        next_cycle();
        @(negedge clk); chk("redir2_in_flush", 32'(ctl), 32'(C_REDIR));
        next_cycle();
        mem_redirect = 1'b0;
        @(negedge clk); chk("redir2_c1", 32'(ctl), 32'(C_FLUSH));
        next_cycle();
        @(negedge clk); chk("redir2_c2", 32'(ctl), 32'(C_NORM));
        chk("redir2_fcnt", 32'(flush_cnt), 32'd3);
        next_cycle();

        // 4-cycle memory wait with a load-use hazard held underneath
        dmem_req = 1'b1; dmem_ready = 1'b0;
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk($sformatf("wait_c%0d", i), 32'(ctl), 32'(C_WAIT));
            next_cycle();
        end
        dmem_ready = 1'b1;
        @(negedge clk); chk("wait_release", 32'(ctl), 32'(C_LU));
        chk("wait_stall", 32'(stall_cnt), 32'd6);
        chk("wait_stall_sat", 32'(s_stall_cnt), 32'd3);
        next_cycle();
        clear_inputs();
        @(negedge clk); chk("wait_after", 32'(ctl), 32'(C_NORM));
        chk("wait_stall2", 32'(stall_cnt), 32'd7);
        chk("wait_no_err", 32'(mem_err), 32'd0);
        next_cycle();

        // redirect pending during a wait is applied on release
        dmem_req = 1'b1; mem_redirect = 1'b1;
        @(negedge clk); chk("wr_wait", 32'(ctl), 32'(C_WAIT));
        next_cycle();
        dmem_ready = 1'b1;
        @(negedge clk); chk("wr_release", 32'(ctl), 32'(C_REDIR));
        next_cycle();
        clear_inputs();
        @(negedge clk); chk("wr_flush", 32'(ctl), 32'(C_FLUSH));
        chk("wr_fcnt", 32'(flush_cnt), 32'd4);
        next_cycle();
        @(negedge clk); chk("wr_norm", 32'(ctl), 32'(C_NORM));
        chk("wr_stall", 32'(stall_cnt), 32'd8);
        next_cycle();

        // timeout with dmem_ready stuck low
        dmem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk($sformatf("to_wait_c%0d", i), 32'(ctl), 32'(C_WAIT));
            next_cycle();
        end
        @(negedge clk); chk("to_release", 32'(ctl), 32'(C_NORM));
        next_cycle();
        dmem_req = 1'b0;
        @(negedge clk); chk("to_err", 32'(mem_err), 32'd1);
        chk("to_stall", 32'(stall_cnt), 32'd12);
        next_cycle();
        next_cycle();
        chk("to_err_sticky", 32'(mem_err), 32'd1);

        // reset while in FLUSH
        mem_redirect = 1'b1;
        next_cycle();
        mem_redirect = 1'b0;
        rst = 1'b0;
        #1 chk("rst_flush_ctl", 32'(ctl), 32'(C_RST));
        chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        chk("rst_err", 32'(mem_err), 32'd0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk); chk("rst_flush_run", 32'(ctl), 32'(C_NORM));
        next_cycle();

        // reset while in MEM_WAIT
        dmem_req = 1'b1;
        @(negedge clk); chk("rst_wait_pre", 32'(ctl), 32'(C_WAIT));
        next_cycle();
        rst = 1'b0;
        #1 chk("rst_wait_ctl", 32'(ctl), 32'(C_RST));
        chk("rst_wait_stall", 32'(stall_cnt), 32'd0);
        next_cycle();
        dmem_req = 1'b0;
        rst = 1'b1;
        @(negedge clk); chk("rst_wait_run", 32'(ctl), 32'(C_NORM));
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
